dpram_port_arbiter: RTL and testbench

- Shares one MEM-side port of the dual-port RAM between NUM_REQ requesters, e.g. the CPU core and the SPI slave engine.
- Each requester has a valid/ready command channel. The arbiter uses round-robin selection, registers the winning command onto the RAM port, and routes read data back to the issuing requester.
- Sits between the requesters and the RAM port's MEM modport; the requester side mirrors the CPU-modport signal set.

---
 rtl/dpram_port_arbiter_pkg.sv | 21 ++
 rtl/dpram_port_arbiter_rr.sv | 34 +++
 rtl/dpram_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_dpram_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_port_arbiter_pkg.sv
// Shared types and constants for the dual-port RAM MEM-side arbiter.
package dpram_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int LOCK_MAX       = 4;

  typedef logic [1:0] req_id_t;

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } mem_cmd_t;

  typedef struct packed {
    logic    is_read;
    req_id_t id;
  } rd_tag_t;

endpackage

// File: rtl/dpram_port_arbiter_rr.sv
// Combinational round-robin pick: first requesting index at or above ptr, wrapping.
module rr_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            ptr,
  output logic [NUM_REQ-1:0] grant,
  output req_id_t            grant_idx
);

  logic [2:0] idx;
  logic       found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= 3'(NUM_REQ)) idx = idx - 3'(NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && idx == 3'(i) && req[i]) begin
          grant[i]  = 1'b1;
          grant_idx = req_id_t'(i);
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin sharing of one RAM MEM port between NUM_REQ requesters with read-data routing.
// Optional atomic-lock support (req_lock port) is built when DPRAM_ARB_LOCK_EN is defined.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
`ifdef DPRAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  logic [NUM_REQ-1:0]    grant;
  req_id_t               grant_idx;
  req_id_t               ptr;
  req_id_t               ptr_adv;
  logic                  accept;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  en_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  rd_tag_t               tag_pipe [RD_LATENCY+1];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // No grant is offered while reset is sampled, so nothing is accepted then.
  assign req_ready = rst ? '0 : grant;
  assign accept    = |req_ready;
  assign ptr_adv   = (grant_idx == req_id_t'(NUM_REQ-1)) ? '0 : grant_idx + req_id_t'(1);

`ifdef DPRAM_ARB_LOCK_EN
  logic [2:0] lock_cnt;
  logic       locked;

  assign locked = |(req_lock & grant);

  // Hold priority on locked accepts, but force a rotation after LOCK_MAX in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      lock_cnt <= '0;
    end else if (accept) begin
      if (locked && lock_cnt < 3'(LOCK_MAX-1)) begin
        ptr      <= grant_idx;
        lock_cnt <= lock_cnt + 3'd1;
      end else begin
        ptr      <= ptr_adv;
        lock_cnt <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= ptr_adv;
    end
  end
`endif

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      en_q <= accept;
      if (accept) begin
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
    end
  end

  assign mem_en    = en_q & ~rst;
  assign mem_we    = en_q & we_q & ~rst;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Stage 0 lines up with the command on the RAM port; the last stage with valid mem_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= RD_LATENCY; k++) tag_pipe[k] <= '0;
    end else begin
      tag_pipe[0].is_read <= accept & ~sel_we;
      tag_pipe[0].id      <= grant_idx;
      for (int k = 1; k <= RD_LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst && tag_pipe[RD_LATENCY].is_read && tag_pipe[RD_LATENCY].id == req_id_t'(i))
        rsp_valid[i] = 1'b1;
    end
  end

  assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed and random bench for dpram_port_arbiter against a cycle-level transaction model.
module tb_dpram_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int RL = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_we, req_ready, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rsp_rdata, mem_wdata, mem_rdata;
  logic              mem_en, mem_we;
  logic [AW-1:0]     mem_addr;
`ifdef DPRAM_ARB_LOCK_EN
  logic [NR-1:0]     req_lock;
`endif

  always #5 clk = ~clk;

  dpram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .RD_LATENCY(RL)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DPRAM_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // RAM with one-cycle read latency; contents forgotten on reset.
  logic [DW-1:0] ram   [256];
  bit            ram_w [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram_w[i] <= 1'b0;
    end else if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]   <= mem_wdata;
        ram_w[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_w[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
      end
    end
  end

  // Reference model state
  int            ptr_m, lock_m, cyc;
  bit            exp_en, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  int            exp_id;
  bit            rv_m  [8];
  int            rid_m [8];
  logic [DW-1:0] rd_m  [8];
  logic [DW-1:0] shadow   [256];
  bit            shadow_w [256];

  // Requester-side stimulus state
  bit            pend   [NR];
  bit            c_we   [NR];
  bit            c_lock [NR];
  logic [AW-1:0] c_addr [NR];
  logic [DW-1:0] c_wdata[NR];
  int            mode;

  int            grant_q[$];
  int            rsp0_cnt, rsp1_cnt;
  logic [DW-1:0] last_rsp0;
  int            n_err, n_chk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int find_grant();
    for (int k = 0; k < NR; k++) begin
      if (pend[(ptr_m + k) % NR]) return (ptr_m + k) % NR;
    end
    return -1;
  endfunction

  task automatic rand_cmd(input int i);
    pend[i]    = 1'b1;
    c_we[i]    = ($urandom % 2) == 1;
    c_addr[i]  = AW'($urandom % 32);
    c_wdata[i] = $urandom;
    c_lock[i]  = 1'b0;
`ifdef DPRAM_ARB_LOCK_EN
    c_lock[i]  = ($urandom % 3) == 0;
`endif
  endtask

  task automatic set_cmd(input int i, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit lk);
    pend[i] = 1'b1; c_we[i] = we; c_addr[i] = a; c_wdata[i] = d; c_lock[i] = lk;
  endtask

  task automatic cycle(input bit r);
    logic [NR-1:0] exp_ready, exp_rv;
    int g, slot, s2;
    rst = r;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]            = pend[i];
      req_we[i]               = c_we[i];
      req_addr[i*AW +: AW]    = c_addr[i];
      req_wdata[i*DW +: DW]   = c_wdata[i];
`ifdef DPRAM_ARB_LOCK_EN
      req_lock[i]             = c_lock[i];
`endif
    end
    g = r ? -1 : find_grant();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    slot = cyc % 8;
    exp_rv = '0;
    if (!r && rv_m[slot]) exp_rv[rid_m[slot]] = 1'b1;

    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("mem_en", 64'(mem_en), 64'(!r && exp_en));
    chk("mem_we", 64'(mem_we), 64'(!r && exp_en && exp_we));
    if (!r && exp_en) begin
      chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
      if (exp_we) chk("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv != '0) chk("rsp_rdata", 64'(rsp_rdata), 64'(rd_m[slot]));
    if (rsp_valid[0]) begin last_rsp0 = rsp_rdata; rsp0_cnt++; end
    if (rsp_valid[1]) rsp1_cnt++;

    @(posedge clk);
    rv_m[slot] = 1'b0;
    if (r) begin
      ptr_m = 0; lock_m = 0; exp_en = 1'b0;
      for (int k = 0; k < 8; k++) rv_m[k] = 1'b0;
      for (int k = 0; k < 256; k++) shadow_w[k] = 1'b0;
    end else begin
      // The command on the port this cycle executes now; reads return RL cycles later.
      if (exp_en) begin
        if (exp_we) begin
          shadow[exp_addr] = exp_wdata; shadow_w[exp_addr] = 1'b1;
        end else begin
          s2 = (cyc + RL) % 8;
          rv_m[s2]  = 1'b1;
          rid_m[s2] = exp_id;
          rd_m[s2]  = shadow_w[exp_addr] ? shadow[exp_addr] : init_val(exp_addr);
        end
      end
      exp_en = (g >= 0);
      if (g >= 0) begin
        exp_we = c_we[g]; exp_addr = c_addr[g]; exp_wdata = c_wdata[g]; exp_id = g;
        grant_q.push_back(g);
        pend[g] = 1'b0;
        if (c_lock[g] && lock_m < 3) begin
          ptr_m = g; lock_m++;
        end else begin
          ptr_m = (g + 1) % NR; lock_m = 0;
        end
      end
    end
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (!pend[i] && (mode == 1 || (mode == 2 && ($urandom % 2) == 1))) rand_cmd(i);
    end
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 16; k++) begin
      if (!pend[0] && !pend[1]) break;
      cycle(1'b0);
    end
    chk("drain", 64'(pend[0] | pend[1]), 64'(0));
    for (int k = 0; k < 4; k++) cycle(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, rep, issued;
    n_err = 0; n_chk = 0; cyc = 0; mode = 0;
    rsp0_cnt = 0; rsp1_cnt = 0; last_rsp0 = '0;
    ptr_m = 0; lock_m = 0; exp_en = 1'b0; exp_we = 1'b0; exp_id = 0;
    exp_addr = '0; exp_wdata = '0;
    for (int k = 0; k < 8; k++) begin rv_m[k] = 1'b0; rid_m[k] = 0; rd_m[k] = '0; end
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0; c_we[i] = 1'b0; c_lock[i] = 1'b0; c_addr[i] = '0; c_wdata[i] = '0;
    end
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
`ifdef DPRAM_ARB_LOCK_EN
    req_lock = '0;
`endif
    @(posedge clk); #1;

    // Reset held with both requesters valid, then requester 0 wins first.
    set_cmd(0, 1'b0, 8'h40, '0, 1'b0);
    set_cmd(1, 1'b0, 8'h41, '0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1);
    grant_q.delete();
    cycle(1'b0);
    chk("first_grant", 64'(grant_q.size() > 0 ? grant_q[0] : -1), 64'(0));
    drain();

    // Single read of the preloaded word.
    rsp0_cnt = 0;
    set_cmd(0, 1'b0, 8'h10, '0, 1'b0);
    drain();
    chk("single_rd_cnt", 64'(rsp0_cnt), 64'(1));
    chk("single_rd_data", 64'(last_rsp0), 64'(32'hDEADBEEF));

    // Full contention for 8 cycles.
    rand_cmd(0); rand_cmd(1);
    for (int i = 0; i < NR; i++) c_lock[i] = 1'b0;
    mode = 1;
    grant_q.delete();
    for (int k = 0; k < 8; k++) cycle(1'b0);
    mode = 0;
    n0 = 0; n1 = 0; rep = 0;
    foreach (grant_q[k]) begin
      if (grant_q[k] == 0) n0++; else n1++;
      if (k > 0 && grant_q[k] == grant_q[k-1]) rep++;
    end
    chk("cont_grants0", 64'(n0), 64'(4));
    chk("cont_grants1", 64'(n1), 64'(4));
    chk("cont_repeats", 64'(rep), 64'(0));
    for (int i = 0; i < NR; i++) c_lock[i] = 1'b0;
    drain();

    // Write by requester 1, read back by requester 0.
    rsp0_cnt = 0; rsp1_cnt = 0;
    set_cmd(1, 1'b1, 8'h20, 32'hA5A5A5A5, 1'b0);
    cycle(1'b0);
    set_cmd(0, 1'b0, 8'h20, '0, 1'b0);
    drain();
    chk("wr_rd_data", 64'(last_rsp0), 64'(32'hA5A5A5A5));
    chk("wr_rd_cnt0", 64'(rsp0_cnt), 64'(1));
    chk("wr_rd_cnt1", 64'(rsp1_cnt), 64'(0));

    // Reset right after a read is accepted discards it.
    rsp0_cnt = 0;
    set_cmd(0, 1'b0, 8'h30, '0, 1'b0);
    cycle(1'b0);
    cycle(1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b0);
    chk("rst_mid_rd", 64'(rsp0_cnt), 64'(0));

`ifdef DPRAM_ARB_LOCK_EN
    // Locked writes by requester 0 against a waiting requester 1.
    cycle(1'b1);
    grant_q.delete();
    issued = 0;
    set_cmd(1, 1'b1, 8'h50, 32'h11111111, 1'b0);
    for (int k = 0; k < 12; k++) begin
      if (!pend[0] && issued < 6) begin
        set_cmd(0, 1'b1, AW'(8'h60 + issued), 32'h22220000 + issued, 1'b1);
        issued++;
      end
      cycle(1'b0);
    end
    begin
      int exp_seq [7] = '{0, 0, 0, 0, 1, 0, 0};
      for (int k = 0; k < 7; k++)
        chk($sformatf("lock_seq%0d", k), 64'(grant_q.size() > k ? grant_q[k] : -1), 64'(exp_seq[k]));
    end
    drain();
`else
    issued = 0;
`endif

    // Randomized traffic with occasional resets.
    mode = 2;
    for (int k = 0; k < 3000; k++) cycle(($urandom % 200) == 0);
    mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
